// File: rtl/ex_stall_sequencer.sv
// EX-stage pipeline controller: sequences multi-cycle units, load-use bubbles and
// redirect flushes for ID/EX, IF/ID and PC, with a BUSY watchdog and stall counter.
module ex_stall_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_multicycle,
  input  logic             unit_done,
  input  logic             redirect,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_fp,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rs3_addr,
  input  logic [2:0]       id_use_rs,
  input  logic [2:0]       id_rs_fp,
  output logic             unit_start,
  output logic             unit_abort,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             ifid_stall,
  output logic             pc_stall,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q;

  logic       start_c, abort_c, hold_c, flush_c, ifid_c, pc_c, tmo_c;
  logic [2:0] rs_match;
  logic       load_use;

  // An integer x0 destination can never carry a real dependency; FP f0 can.
  always_comb begin
    rs_match[0] = id_use_rs[0] && (id_rs1_addr == ex_rd_addr) && (id_rs_fp[0] == ex_rd_fp);
    rs_match[1] = id_use_rs[1] && (id_rs2_addr == ex_rd_addr) && (id_rs_fp[1] == ex_rd_fp);
    rs_match[2] = id_use_rs[2] && (id_rs3_addr == ex_rd_addr) && (id_rs_fp[2] == ex_rd_fp);
    load_use    = ex_valid && ex_mem_read && (|rs_match)
                  && !(!ex_rd_fp && (ex_rd_addr == 5'd0));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    start_c = (state_q == IDLE) && ex_valid && ex_multicycle && !redirect;
    abort_c = 1'b0;
    hold_c  = 1'b0;
    flush_c = 1'b0;
    ifid_c  = 1'b0;
    pc_c    = 1'b0;
    tmo_c   = 1'b0;
    // Redirect overrides everything, including a same-cycle unit_done.
    if (redirect) begin
      flush_c = 1'b1;
      abort_c = (state_q == BUSY);
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            hold_c  = 1'b1;
            ifid_c  = 1'b1;
            pc_c    = 1'b1;
            state_d = BUSY;
            timer_d = TW'(1);
          end else if (load_use) begin
            flush_c = 1'b1;
            ifid_c  = 1'b1;
            pc_c    = 1'b1;
          end
        end
        BUSY: begin
          hold_c  = 1'b1;
          ifid_c  = 1'b1;
          pc_c    = 1'b1;
          timer_d = timer_q + TW'(1);
          if (unit_done) begin
            state_d = RELEASE;
            timer_d = '0;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_c   = 1'b1;
            abort_c = 1'b1;
            state_d = RELEASE;
            timer_d = '0;
          end
        end
        RELEASE: begin
          state_d = IDLE;
          timer_d = '0;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pc_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Combinational handshakes are forced low while reset is asserted.
  assign unit_start   = reset_n && start_c;
  assign unit_abort   = reset_n && abort_c;
  assign idex_hold    = reset_n && hold_c;
  assign idex_flush   = reset_n && flush_c;
  assign ifid_stall   = reset_n && ifid_c;
  assign pc_stall     = reset_n && pc_c;
  assign timeout_err  = reset_n && tmo_c;
  assign busy         = reset_n && (state_q == BUSY);
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_ex_stall_sequencer.sv
// Directed bench for ex_stall_sequencer with a cycle-level reference model.
module tb_ex_stall_sequencer;

  localparam int TMO     = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk, reset_n;
  logic          ex_valid, ex_multicycle, unit_done, redirect, ex_mem_read, ex_rd_fp;
  logic [4:0]    ex_rd_addr, id_rs1_addr, id_rs2_addr, id_rs3_addr;
  logic [2:0]    id_use_rs, id_rs_fp;
  logic          unit_start, unit_abort, idex_hold, idex_flush, ifid_stall, pc_stall;
  logic          busy, timeout_err;
  logic [CW-1:0] stall_cycles;

  int n_pass  = 0;
  int n_total = 0;

  ex_stall_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_multicycle(ex_multicycle), .unit_done(unit_done),
    .redirect(redirect), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_rd_fp(ex_rd_fp), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs3_addr(id_rs3_addr), .id_use_rs(id_use_rs), .id_rs_fp(id_rs_fp),
    .unit_start(unit_start), .unit_abort(unit_abort), .idex_hold(idex_hold),
    .idex_flush(idex_flush), .ifid_stall(ifid_stall), .pc_stall(pc_stall),
    .busy(busy), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: age counts BUSY cycles (0 = not busy); rel marks the release cycle.
  int m_age, m_rel, m_cnt;

  typedef struct packed {
    logic start, abort, hold, flush, ifid, pc, bsy, tmo;
  } exp_t;

  function automatic bit model_load_use();
    logic [4:0] rs [3];
    rs[0] = id_rs1_addr; rs[1] = id_rs2_addr; rs[2] = id_rs3_addr;
    if (!(ex_valid && ex_mem_read)) return 1'b0;
    if (!ex_rd_fp && ex_rd_addr == 5'd0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (id_use_rs[i] && rs[i] == ex_rd_addr && id_rs_fp[i] == ex_rd_fp) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    if (!reset_n) return e;
    e.bsy = (m_age > 0);
    if (redirect) begin
      e.flush = 1'b1;
      e.abort = (m_age > 0);
    end else if (m_age > 0) begin
      e.hold = 1'b1; e.ifid = 1'b1; e.pc = 1'b1;
      if (!unit_done && m_age == TMO - 1) begin
        e.tmo = 1'b1; e.abort = 1'b1;
      end
    end else if (m_rel == 0 && ex_valid && ex_multicycle) begin
      e.start = 1'b1; e.hold = 1'b1; e.ifid = 1'b1; e.pc = 1'b1;
    end else if (m_rel == 0 && model_load_use()) begin
      e.flush = 1'b1; e.ifid = 1'b1; e.pc = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      m_age = 0; m_rel = 0; m_cnt = 0;
    end else begin
      e = expect_now();
      if (e.pc && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (redirect) begin
        m_age = 0; m_rel = 0;
      end else if (m_age > 0) begin
        if (unit_done || e.tmo) begin m_age = 0; m_rel = 1; end
        else m_age = m_age + 1;
      end else if (e.start) begin
        m_age = 1; m_rel = 0;
      end else begin
        m_rel = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = expect_now();
    chk("unit_start",   32'(unit_start),   32'(e.start));
    chk("unit_abort",   32'(unit_abort),   32'(e.abort));
    chk("idex_hold",    32'(idex_hold),    32'(e.hold));
    chk("idex_flush",   32'(idex_flush),   32'(e.flush));
    chk("ifid_stall",   32'(ifid_stall),   32'(e.ifid));
    chk("pc_stall",     32'(pc_stall),     32'(e.pc));
    chk("busy",         32'(busy),         32'(e.bsy));
    chk("timeout_err",  32'(timeout_err),  32'(e.tmo));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  end

  task automatic idle_in();
    ex_valid = 0; ex_multicycle = 0; unit_done = 0; redirect = 0; ex_mem_read = 0;
    ex_rd_addr = 0; ex_rd_fp = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs3_addr = 0;
    id_use_rs = 0; id_rs_fp = 0;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic rdfp, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] r3,
                        input logic [2:0] use_rs, input logic [2:0] rsfp);
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = rd; ex_rd_fp = rdfp;
    id_rs1_addr = r1; id_rs2_addr = r2; id_rs3_addr = r3;
    id_use_rs = use_rs; id_rs_fp = rsfp;
  endtask

  initial begin
    int starts;
    reset_n = 0;
    idle_in();
    ex_valid = 1; ex_multicycle = 1; redirect = 1;
    at_neg();
    chk("rst_start", 32'(unit_start), 0);
    chk("rst_flush", 32'(idex_flush), 0);
    adv();
    reset_n = 1;
    idle_in();
    adv(); adv();

    // MUL, done 5 cycles after start
    ex_valid = 1; ex_multicycle = 1;
    at_neg();
    chk("mul_start_c0", 32'(unit_start), 1);
    chk("mul_hold_c0", 32'(idex_hold), 1);
    adv();
    for (int k = 1; k <= 4; k++) begin
      at_neg();
      chk("mul_busy", 32'(busy), 1);
      chk("mul_nostart", 32'(unit_start), 0);
      adv();
    end
    unit_done = 1;
    at_neg();
    chk("mul_hold_c5", 32'(idex_hold), 1);
    adv();
    unit_done = 0;
    at_neg();
    chk("mul_rel_start", 32'(unit_start), 0);
    chk("mul_rel_hold", 32'(idex_hold), 0);
    chk("mul_rel_cnt", 32'(stall_cycles), 6);
    adv();
    idle_in();
    at_neg();
    chk("mul_idle_busy", 32'(busy), 0);
    adv();

    // Back-to-back MULs
    starts = 0;
    ex_valid = 1; ex_multicycle = 1;
    for (int c = 0; c <= 8; c++) begin
      unit_done = (c == 2 || c == 6);
      if (c == 8) begin ex_valid = 0; ex_multicycle = 0; end
      at_neg();
      starts += int'(unit_start);
      adv();
    end
    chk("b2b_starts", 32'(starts), 2);
    idle_in();
    adv();

    // Load-use: LW x5 / ADD x6,x5,x1
    set_lu(5'd5, 1'b0, 5'd5, 5'd1, 5'd0, 3'b011, 3'b000);
    at_neg();
    chk("lu_flush", 32'(idex_flush), 1);
    chk("lu_pc", 32'(pc_stall), 1);
    chk("lu_hold", 32'(idex_hold), 0);
    adv();
    ex_valid = 0; ex_mem_read = 0;
    at_neg();
    chk("lu_bubble_pc", 32'(pc_stall), 0);
    adv();
    set_lu(5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b011, 3'b000);
    at_neg();
    chk("lu_x0", 32'(pc_stall), 0);
    adv();
    set_lu(5'd0, 1'b1, 5'd0, 5'd3, 5'd0, 3'b001, 3'b001);
    at_neg();
    chk("lu_f0", 32'(pc_stall), 1);
    adv();
    set_lu(5'd7, 1'b0, 5'd1, 5'd2, 5'd7, 3'b100, 3'b100);
    at_neg();
    chk("lu_rs3_fpdiff", 32'(pc_stall), 0);
    adv();
    id_rs_fp = 3'b000;
    at_neg();
    chk("lu_rs3", 32'(idex_flush), 1);
    adv();
    set_lu(5'd7, 1'b0, 5'd7, 5'd2, 5'd3, 3'b000, 3'b000);
    at_neg();
    chk("lu_unused", 32'(pc_stall), 0);
    adv();
    idle_in();
    adv();

    // DIV busy 3 cycles then redirect
    ex_valid = 1; ex_multicycle = 1;
    at_neg();
    chk("div_start", 32'(unit_start), 1);
    adv(); adv(); adv(); adv();
    redirect = 1;
    at_neg();
    chk("div_abort", 32'(unit_abort), 1);
    chk("div_flush", 32'(idex_flush), 1);
    chk("div_hold", 32'(idex_hold), 0);
    adv();
    idle_in();
    at_neg();
    chk("div_idle", 32'(busy), 0);
    chk("div_abort_once", 32'(unit_abort), 0);
    adv();

    // Redirect with same-cycle unit_done: back to IDLE, not RELEASE
    ex_valid = 1; ex_multicycle = 1;
    adv(); adv();
    unit_done = 1; redirect = 1;
    at_neg();
    chk("rd_done_abort", 32'(unit_abort), 1);
    adv();
    unit_done = 0; redirect = 0;
    at_neg();
    chk("rd_done_restart", 32'(unit_start), 1);
    adv();
    unit_done = 1;
    adv();
    idle_in();
    adv(); adv();

    // Watchdog with TIMEOUT_CYCLES=8
    ex_valid = 1; ex_multicycle = 1;
    adv();
    for (int k = 1; k <= 7; k++) begin
      at_neg();
      if (k == 7) begin
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_abort", 32'(unit_abort), 1);
      end else if (k == 6) begin
        chk("tmo_early", 32'(timeout_err), 0);
      end
      adv();
    end
    at_neg();
    chk("tmo_rel_busy", 32'(busy), 0);
    chk("tmo_rel_start", 32'(unit_start), 0);
    chk("tmo_rel_err", 32'(timeout_err), 0);
    adv();
    idle_in();
    adv();

    // Reset mid-BUSY
    ex_valid = 1; ex_multicycle = 1;
    adv(); adv();
    reset_n = 0;
    #1;
    chk("rstb_hold", 32'(idex_hold), 0);
    chk("rstb_abort", 32'(unit_abort), 0);
    chk("rstb_busy", 32'(busy), 0);
    chk("rstb_cnt", 32'(stall_cycles), 0);
    adv();
    reset_n = 1;
    idle_in();
    at_neg();
    chk("rstb_idle", 32'(busy), 0);
    adv();

    // Counter saturation with CNT_W=4
    set_lu(5'd5, 1'b0, 5'd5, 5'd0, 5'd0, 3'b001, 3'b000);
    repeat (20) adv();
    at_neg();
    chk("sat_15", 32'(stall_cycles), 15);
    adv();
    idle_in();
    adv(); adv();
    chk("sat_hold", 32'(stall_cycles), 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
